// File: rtl/button_pulser.sv
// rtl/button_pulser.sv - four-button debouncer with auto-repeat and prioritised one-cycle command pulses
module button_pulser #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [7:0]  REPEAT_DELAY    = 8'd50,
   parameter logic [7:0]  REPEAT_RATE     = 8'd10
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       slow_clock,
   input  logic       btnDigit,
   input  logic       btnSel,
   input  logic       btnResetDigit,
   input  logic       btnResetSel,
   output logic       incDigit,
   output logic       incSelection,
   output logic       resetDigit,
   output logic       resetSel,
   output logic [3:0] pressedMask
);

   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rep_state_t;

   // Bit order everywhere: {resetSel, resetDigit, sel, digit}
   logic [3:0]  raw, sync1, sync2, level, level_q, press, fall, cand_q;
   logic [19:0] db_cnt [4];
   rep_state_t  state [2];
   rep_state_t  state_nxt [2];
   logic [7:0]  tick_cnt [2];
   logic [7:0]  tick_cnt_nxt [2];
   logic [1:0]  rep_fire;
   logic        inc_digit_ok, inc_sel_ok;

   assign raw   = {btnResetSel, btnResetDigit, btnSel, btnDigit};
   assign press = level & ~level_q;
   assign fall  = ~level & level_q;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] + 20'd1 == DEBOUNCE_CYCLES) begin
               db_cnt[i] <= '0;
               level[i]  <= ~level[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 20'd1;
            end
         end
      end
   end

   // Auto-repeat for digit and sel; a debounced release always wins over a tick.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_nxt[i]    = state[i];
         tick_cnt_nxt[i] = tick_cnt[i];
         rep_fire[i]     = 1'b0;
         if (fall[i]) begin
            state_nxt[i]    = IDLE;
            tick_cnt_nxt[i] = '0;
         end else begin
            case (state[i])
               IDLE: begin
                  if (press[i]) begin
                     state_nxt[i]    = DELAY;
                     tick_cnt_nxt[i] = '0;
                  end
               end
               DELAY: begin
                  if (slow_clock) begin
                     if (tick_cnt[i] + 8'd1 == REPEAT_DELAY) begin
                        rep_fire[i]     = 1'b1;
                        tick_cnt_nxt[i] = '0;
                        state_nxt[i]    = REPEAT;
                     end else begin
                        tick_cnt_nxt[i] = tick_cnt[i] + 8'd1;
                     end
                  end
               end
               REPEAT: begin
                  if (slow_clock) begin
                     if (tick_cnt[i] + 8'd1 == REPEAT_RATE) begin
                        rep_fire[i]     = 1'b1;
                        tick_cnt_nxt[i] = '0;
                     end else begin
                        tick_cnt_nxt[i] = tick_cnt[i] + 8'd1;
                     end
                  end
               end
               default: begin
                  state_nxt[i]    = IDLE;
                  tick_cnt_nxt[i] = '0;
               end
            endcase
         end
      end
   end

   // Increments are suppressed while the matching reset button is held.
   assign inc_digit_ok = cand_q[0] & ~level[2];
   assign inc_sel_ok   = cand_q[1] & ~level[3];

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < 2; i++) begin
            state[i]    <= IDLE;
            tick_cnt[i] <= '0;
         end
         cand_q       <= '0;
         pressedMask  <= '0;
         resetDigit   <= 1'b0;
         resetSel     <= 1'b0;
         incDigit     <= 1'b0;
         incSelection <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state[i]    <= state_nxt[i];
            tick_cnt[i] <= tick_cnt_nxt[i];
         end
         cand_q       <= {press[3], press[2], press[1] | rep_fire[1], press[0] | rep_fire[0]};
         pressedMask  <= level;
         resetDigit   <= cand_q[2];
         resetSel     <= cand_q[3] & ~cand_q[2];
         incDigit     <= inc_digit_ok & ~cand_q[2] & ~cand_q[3];
         incSelection <= inc_sel_ok & ~cand_q[2] & ~cand_q[3] & ~inc_digit_ok;
      end
   end

endmodule

// File: tb/tb_button_pulser.sv
// tb/tb_button_pulser.sv - directed bench for button_pulser with an in-bench behavioural model
module tb_button_pulser;

   localparam int D  = 4;
   localparam int RD = 3;
   localparam int RR = 2;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       slow_clock = 1'b0;
   logic       btnDigit = 1'b0, btnSel = 1'b0, btnResetDigit = 1'b0, btnResetSel = 1'b0;
   logic       incDigit, incSelection, resetDigit, resetSel;
   logic [3:0] pressedMask;

   button_pulser #(
      .DEBOUNCE_CYCLES(20'd4),
      .REPEAT_DELAY   (8'd3),
      .REPEAT_RATE    (8'd2)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .slow_clock   (slow_clock),
      .btnDigit     (btnDigit),
      .btnSel       (btnSel),
      .btnResetDigit(btnResetDigit),
      .btnResetSel  (btnResetSel),
      .incDigit     (incDigit),
      .incSelection (incSelection),
      .resetDigit   (resetDigit),
      .resetSel     (resetSel),
      .pressedMask  (pressedMask)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int ec = -1;

   // Model state; index 0 digit, 1 sel, 2 resetDigit, 3 resetSel
   bit         hist [4][8192];
   logic [3:0] lvl = '0, lvl_d = '0, cand = '0, active = '0;
   int         ticks [4];
   logic [3:0] exp_out, exp_mask;
   int         pq [4][$];
   logic [3:0] mask_or;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ec);
      end
   endtask

   // Ticks land on every edge whose index is a multiple of 5.
   always @(negedge clk) slow_clock = ((ec + 1) % 5 == 0);

   task automatic model_step(int k);
      logic [3:0] raw_now, old;
      bit         all_diff;
      int         idx;
      raw_now = {btnResetSel, btnResetDigit, btnSel, btnDigit};
      if (!resetN) begin
         for (int b = 0; b < 4; b++) begin
            hist[b][k] = 1'b0;
            if (k > 0) hist[b][k-1] = 1'b0;
            ticks[b] = 0;
         end
         lvl = '0; lvl_d = '0; cand = '0; active = '0;
         exp_out = '0; exp_mask = '0;
      end else begin
         for (int b = 0; b < 4; b++) hist[b][k] = raw_now[b];
         exp_mask = lvl;
         exp_out  = '0;
         if (cand[2])                exp_out[2] = 1'b1;
         else if (cand[3])           exp_out[3] = 1'b1;
         else if (cand[0] && !lvl[2]) exp_out[0] = 1'b1;
         else if (cand[1] && !lvl[3]) exp_out[1] = 1'b1;
         old = lvl;
         for (int b = 0; b < 4; b++) begin
            cand[b] = old[b] & ~lvl_d[b];
            if (b < 2) begin
               if (!old[b] && lvl_d[b]) begin
                  active[b] = 1'b0;
               end else if (active[b] && slow_clock) begin
                  ticks[b]++;
                  if (ticks[b] == RD || (ticks[b] > RD && (ticks[b] - RD) % RR == 0)) cand[b] = 1'b1;
               end
               if (old[b] && !lvl_d[b]) begin
                  active[b] = 1'b1;
                  ticks[b]  = 0;
               end
            end
         end
         lvl_d = old;
         // A level flips once the last D synchronized samples all disagree with it.
         for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
               idx = k - 2 - j;
               if (((idx >= 0) ? hist[b][idx] : 1'b0) == old[b]) all_diff = 1'b0;
            end
            if (all_diff) lvl[b] = ~old[b];
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      ec++;
      model_step(ec);
      chk("pulses", {resetSel, resetDigit, incSelection, incDigit}, exp_out);
      chk("pressedMask", pressedMask, exp_mask);
      if (incDigit)     pq[0].push_back(ec);
      if (incSelection) pq[1].push_back(ec);
      if (resetDigit)   pq[2].push_back(ec);
      if (resetSel)     pq[3].push_back(ec);
      mask_or = mask_or | pressedMask;
   end

   task automatic clear_log();
      for (int i = 0; i < 4; i++) pq[i].delete();
      mask_or = '0;
   endtask

   task automatic wait_to(int e);
      while (ec < e) @(negedge clk);
   endtask

   task automatic align5();
      do @(negedge clk); while ((ec + 1) % 5 != 0);
   endtask

   function automatic int nth(int o, int n);
      return (pq[o].size() > n) ? pq[o][n] : -1;
   endfunction

   int base, rel;

   initial begin
      mask_or = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {resetSel, resetDigit, incSelection, incDigit}, 0);
      chk("reset_mask", pressedMask, 0);
      resetN = 1'b1;
      repeat (5) @(negedge clk);

      // Clean resetSel press
      clear_log();
      btnResetSel = 1'b1; base = ec + 1;
      wait_to(base + 5);
      chk("rs_mask_before", pressedMask, 0);
      wait_to(base + 6);
      chk("rs_mask_at6", pressedMask, 4'b1000);
      wait_to(base + 25);
      chk("rs_count", pq[3].size(), 1);
      chk("rs_edge", nth(3, 0), base + 7);
      btnResetSel = 1'b0;
      repeat (15) @(negedge clk);

      // Bouncing sel, then held
      clear_log();
      base = ec + 1;
      for (int p = 0; p < 4; p++) begin
         btnSel = (p % 2 == 0);
         repeat (3) @(negedge clk);
      end
      btnSel = 1'b1;
      wait_to(base + 17);
      chk("bounce_mask_low", pressedMask[1], 0);
      wait_to(base + 18);
      chk("bounce_mask_high", pressedMask[1], 1);
      wait_to(base + 26);
      chk("bounce_first", nth(1, 0), base + 19);
      btnSel = 1'b0;
      repeat (15) @(negedge clk);

      // Sel held 40 cycles: initial pulse then auto-repeat
      clear_log();
      align5();
      btnSel = 1'b1; base = ec + 1;
      wait_to(base + 39);
      btnSel = 1'b0;
      wait_to(base + 60);
      chk("rep_count", pq[1].size(), 4);
      chk("rep_p0", nth(1, 0), base + 7);
      chk("rep_p1", nth(1, 1), base + 21);
      chk("rep_p2", nth(1, 2), base + 31);
      chk("rep_p3", nth(1, 3), base + 41);

      // resetDigit and digit together
      clear_log();
      align5();
      btnResetDigit = 1'b1; btnDigit = 1'b1; base = ec + 1;
      wait_to(base + 39);
      btnResetDigit = 1'b0; btnDigit = 1'b0;
      wait_to(base + 60);
      chk("rd_count", pq[2].size(), 1);
      chk("rd_edge", nth(2, 0), base + 7);
      chk("rd_no_inc", pq[0].size(), 0);

      // Reset mid-debounce of a held digit press
      clear_log();
      btnDigit = 1'b1; base = ec + 1;
      wait_to(base + 4);
      resetN = 1'b0;
      wait_to(base + 5);
      resetN = 1'b1;
      wait_to(base + 20);
      chk("midreset_first", nth(0, 0), base + 13);
      btnDigit = 1'b0;
      repeat (15) @(negedge clk);

      // 3-cycle glitch on every button
      clear_log();
      {btnResetSel, btnResetDigit, btnSel, btnDigit} = 4'b1111;
      repeat (3) @(negedge clk);
      {btnResetSel, btnResetDigit, btnSel, btnDigit} = 4'b0000;
      repeat (20) @(negedge clk);
      chk("glitch_pulses", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);
      chk("glitch_mask", mask_or, 0);

      // Button held through reset release
      btnResetSel = 1'b1;
      repeat (12) @(negedge clk);
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1; rel = ec + 1;
      clear_log();
      wait_to(rel + 20);
      chk("held_reset_count", pq[3].size(), 1);
      chk("held_reset_edge", nth(3, 0), rel + 7);
      btnResetSel = 1'b0;
      repeat (15) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
